// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 4;
    localparam int LOCK_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Priority hand-off: after serving one requester the other goes first.
    function automatic req_id_t other_req(input req_id_t id);
        req_id_t res;
        if (id == REQ_A) begin
            res = REQ_B;
        end else begin
            res = REQ_A;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_lock_timer.sv
// Lock duration counter: load to 1 when a lock starts, count every locked
// cycle, saturate at LOCK_MAX and flag expiry while at the limit.
module lock_timer #(
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = $clog2(LOCK_MAX + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic start,
    input  logic inc,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear wins over load, load wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (start) begin
            count_r <= CNT_ONE;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == CNT_MAX);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Round-robin per cycle, optional lock for read-modify-write, lock timeout.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              lock_err_a,
    output logic              lock_err_b,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t  state_r;
    req_id_t     prio_r;
    logic        rvalid_a_r;
    logic        rvalid_b_r;
    logic        lock_err_a_r;
    logic        lock_err_b_r;

    logic        gnt_a_s;
    logic        gnt_b_s;
    logic        timer_clr_s;
    logic        timer_start_s;
    logic        timer_inc_s;
    logic        expire_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (!reset_n) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_a && req_b) begin
                        if (prio_r == REQ_A) begin
                            gnt_a_s = 1'b1;
                        end else begin
                            gnt_b_s = 1'b1;
                        end
                    end else begin
                        gnt_a_s = req_a;
                        gnt_b_s = req_b;
                    end
                end
                LOCK_A: begin
                    gnt_a_s = req_a;
                end
                LOCK_B: begin
                    gnt_b_s = req_b;
                end
                default: begin
                    gnt_a_s = 1'b0;
                    gnt_b_s = 1'b0;
                end
            endcase
        end
    end

    // Lock timer control: load on lock entry, run while locked, clear otherwise.
    always_comb begin
        timer_clr_s   = 1'b0;
        timer_start_s = 1'b0;
        timer_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if ((gnt_a_s && lock_a) || (gnt_b_s && lock_b)) begin
                    timer_start_s = 1'b1;
                end else begin
                    timer_clr_s = 1'b1;
                end
            end
            LOCK_A: begin
                if (!lock_a || expire_s) begin
                    timer_clr_s = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            LOCK_B: begin
                if (!lock_b || expire_s) begin
                    timer_clr_s = 1'b1;
                end else begin
                    timer_inc_s = 1'b1;
                end
            end
            default: begin
                timer_clr_s = 1'b1;
            end
        endcase
    end

    lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr_s),
        .start   (timer_start_s),
        .inc     (timer_inc_s),
        .expire  (expire_s)
    );

    // Arbitration FSM with priority register and timeout error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            prio_r       <= REQ_A;
            lock_err_a_r <= 1'b0;
            lock_err_b_r <= 1'b0;
        end else begin
            lock_err_a_r <= 1'b0;
            lock_err_b_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_a_s) begin
                        prio_r  <= other_req(REQ_A);
                        state_r <= lock_a ? LOCK_A : IDLE;
                    end else if (gnt_b_s) begin
                        prio_r  <= other_req(REQ_B);
                        state_r <= lock_b ? LOCK_B : IDLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCK_A: begin
                    if (!lock_a) begin
                        state_r <= IDLE;
                        prio_r  <= REQ_B;
                    end else if (expire_s) begin
                        state_r      <= IDLE;
                        prio_r       <= REQ_B;
                        lock_err_a_r <= 1'b1;
                    end else begin
                        state_r <= LOCK_A;
                    end
                end
                LOCK_B: begin
                    if (!lock_b) begin
                        state_r <= IDLE;
                        prio_r  <= REQ_A;
                    end else if (expire_s) begin
                        state_r      <= IDLE;
                        prio_r       <= REQ_A;
                        lock_err_b_r <= 1'b1;
                    end else begin
                        state_r <= LOCK_B;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    prio_r  <= REQ_A;
                end
            endcase
        end
    end

    // Read-valid tracking: a granted read shows data exactly one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
        end else begin
            rvalid_a_r <= gnt_a_s && !we_a;
            rvalid_b_r <= gnt_b_s && !we_b;
        end
    end

    // RAM port mux; idle bus is driven to zero.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        if (gnt_a_s) begin
            ram_we_s    = we_a;
            ram_addr_s  = addr_a;
            ram_wdata_s = wdata_a;
        end else if (gnt_b_s) begin
            ram_we_s    = we_b;
            ram_addr_s  = addr_b;
            ram_wdata_s = wdata_b;
        end else begin
            ram_we_s    = 1'b0;
            ram_addr_s  = {ADDR_W{1'b0}};
            ram_wdata_s = {DATA_W{1'b0}};
        end
    end

    assign gnt_a      = gnt_a_s;
    assign gnt_b      = gnt_b_s;
    assign rvalid_a   = rvalid_a_r;
    assign rvalid_b   = rvalid_b_r;
    assign rdata_a    = ram_rdata;
    assign rdata_b    = ram_rdata;
    assign lock_err_a = lock_err_a_r;
    assign lock_err_b = lock_err_b_r;
    assign ram_we     = ram_we_s;
    assign ram_addr   = ram_addr_s;
    assign ram_wdata  = ram_wdata_s;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x4 synchronous RAM.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_a, req_b, lock_a, lock_b, we_a, we_b;
    logic [4:0] addr_a, addr_b;
    logic [3:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, lock_err_a, lock_err_b;
    logic [3:0] rdata_a, rdata_b;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic [3:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    ram_port_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .lock_a     (lock_a),
        .lock_b     (lock_b),
        .we_a       (we_a),
        .we_b       (we_b),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .wdata_a    (wdata_a),
        .wdata_b    (wdata_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .rvalid_a   (rvalid_a),
        .rvalid_b   (rvalid_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .lock_err_a (lock_err_a),
        .lock_err_b (lock_err_b),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM preload: mem[i] = i, except mem[5] = 4'hA.
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] <= 4'(i);
        end
        mem[5] <= 4'hA;
    end

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
        we_a = 1'b0; we_b = 1'b0; addr_a = 5'd0; addr_b = 5'd0;
        wdata_a = 4'd0; wdata_b = 4'd0;
        @(negedge clk);

        // Reset state: requests are ignored while reset is held
        req_a = 1'b1; we_a = 1'b1; addr_a = 5'd7;
        #1;
        chk("rst_gnt_a", gnt_a, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 5'd0);
        chk("rst_rvalid_a", rvalid_a, 1'b0);
        chk("rst_rvalid_b", rvalid_b, 1'b0);
        chk("rst_lock_err_a", lock_err_a, 1'b0);
        chk("rst_lock_err_b", lock_err_b, 1'b0);
        @(negedge clk);

        // Solo read of mem[5]
        reset_n = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 5'd5;
        #1;
        chk("t1_gnt_a", gnt_a, 1'b1);
        chk("t1_gnt_b", gnt_b, 1'b0);
        chk("t1_ram_addr", ram_addr, 5'd5);
        chk("t1_ram_we", ram_we, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        chk("t1_rvalid_a", rvalid_a, 1'b1);
        chk("t1_rdata_a", rdata_a, 4'hA);
        chk("t1_idle_gnt_a", gnt_a, 1'b0);
        chk("t1_idle_addr", ram_addr, 5'd0);
        chk("t1_idle_wdata", ram_wdata, 4'd0);
        @(negedge clk);
        #1;
        chk("t1_rvalid_a_once", rvalid_a, 1'b0);
        @(negedge clk);

        // Contention from reset: A,B,A,B
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; req_a = 1'b1; req_b = 1'b1;
        addr_a = 5'd0; addr_b = 5'd1; we_a = 1'b0; we_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_gnt_a", gnt_a, (i % 2) == 0);
            chk("t2_gnt_b", gnt_b, (i % 2) == 1);
            chk("t2_rvalid_a", rvalid_a, (i % 2) == 1);
            chk("t2_rvalid_b", rvalid_b, (i != 0) && ((i % 2) == 0));
            @(negedge clk);
        end

        // Locked read-modify-write on addr 3, B waits
        lock_a = 1'b1; addr_a = 5'd3; addr_b = 5'd3;
        #1;
        chk("t3_rd_gnt_a", gnt_a, 1'b1);
        chk("t3_rd_gnt_b", gnt_b, 1'b0);
        @(negedge clk);
        req_a = 1'b0;
        #1;
        chk("t3_gap_gnt_a", gnt_a, 1'b0);
        chk("t3_gap_gnt_b", gnt_b, 1'b0);
        chk("t3_rvalid_a", rvalid_a, 1'b1);
        chk("t3_rdata_a", rdata_a, 4'h3);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; wdata_a = 4'h5; lock_a = 1'b0;
        #1;
        chk("t3_wr_gnt_a", gnt_a, 1'b1);
        chk("t3_wr_gnt_b", gnt_b, 1'b0);
        chk("t3_wr_ram_we", ram_we, 1'b1);
        chk("t3_wr_wdata", ram_wdata, 4'h5);
        @(negedge clk);
        req_a = 1'b0; we_a = 1'b0;
        #1;
        chk("t3_b_gnt_b", gnt_b, 1'b1);
        chk("t3_b_addr", ram_addr, 5'd3);
        chk("t3_wr_no_rvalid", rvalid_a, 1'b0);
        @(negedge clk);
        req_b = 1'b0;
        #1;
        chk("t3_rvalid_b", rvalid_b, 1'b1);
        chk("t3_rdata_b", rdata_b, 4'h5);
        @(negedge clk);

        // Lock timeout: A holds lock, req_a dips low mid-lock, B waiting
        lock_a = 1'b1; req_b = 1'b1; addr_a = 5'd0; addr_b = 5'd1;
        for (int i = 0; i < 12; i++) begin
            req_a = !((i == 3) || (i == 4));
            #1;
            chk("t4_gnt_a", gnt_a, req_a && (i != 9));
            chk("t4_gnt_b", gnt_b, i == 9);
            chk("t4_lock_err_a", lock_err_a, i == 9);
            chk("t4_lock_err_b", lock_err_b, 1'b0);
            @(negedge clk);
        end
        req_a = 1'b0; lock_a = 1'b0; req_b = 1'b0;
        #1;
        chk("t4_rel_gnt_a", gnt_a, 1'b0);
        @(negedge clk);

        // Write then read addr 31 from B
        req_b = 1'b1; we_b = 1'b1; addr_b = 5'd31; wdata_b = 4'h7;
        #1;
        chk("t5_wr_gnt_b", gnt_b, 1'b1);
        chk("t5_wr_ram_we", ram_we, 1'b1);
        chk("t5_wr_addr", ram_addr, 5'd31);
        chk("t5_wr_wdata", ram_wdata, 4'h7);
        @(negedge clk);
        we_b = 1'b0;
        #1;
        chk("t5_rd_gnt_b", gnt_b, 1'b1);
        chk("t5_rd_ram_we", ram_we, 1'b0);
        chk("t5_wr_no_rvalid", rvalid_b, 1'b0);
        @(negedge clk);
        req_b = 1'b0;
        #1;
        chk("t5_rvalid_b", rvalid_b, 1'b1);
        chk("t5_rdata_b", rdata_b, 4'h7);
        @(negedge clk);

        // Reset asserted during a granted read
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd5;
        #1;
        chk("t6_gnt_a", gnt_a, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_gnt_a_forced", gnt_a, 1'b0);
        @(negedge clk);
        #1;
        chk("t6_no_rvalid_a", rvalid_a, 1'b0);
        reset_n = 1'b1; req_a = 1'b1; req_b = 1'b1; we_b = 1'b0;
        #1;
        chk("t6_prio_gnt_a", gnt_a, 1'b1);
        chk("t6_prio_gnt_b", gnt_b, 1'b0);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
